mux_select_ctrl: RTL and testbench
==================================

// Module: mux_select_ctrl
// PURPOSE
//  Upstream control stage for the 2:1 mux datapath. It generates the mux select (S) from a raw push-button.
//  It synchronises and debounces the button and toggles the select on each debounced press.
//  It also drives a break-before-make blank window around every switch, so the consumer can force its output low while S changes.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    consecutive stable synchronised samples required to accept a new button level (1..65535)
//  GUARD_CYCLES     2     cycles blank_o is held high before sel_o flips (1..255)
//  AUTO_PERIOD      1000  auto-toggle period in cycles; used only when MUX_SEL_AUTO_EN is defined (>=2)
// PORTS
//  clk        in   1  single clock for the whole block
//  rst        in   1  synchronous reset, active-high
//  btn_in     in   1  raw asynchronous button level (ui_in bit)
//  hold_i     in   1  1 = freeze select; new toggle requests are dropped
//  auto_en_i  in   1  1 = periodic auto-toggle; ignored unless MUX_SEL_AUTO_EN is defined
//  sel_o      out  1  registered mux select; 0 = input A, 1 = input B
//  blank_o    out  1  high during the guard window; the consumer forces its mux output to 0
//  changed_o  out  1  one-cycle pulse in the cycle sel_o takes its new value
//  btn_db_o   out  1  debounced button level (debug/observe)
// BEHAVIOUR
//  Reset: sel_o=0, blank_o=0, changed_o=0, btn_db_o=0, all counters=0, FSM=SEL_A; synchronizer flops cleared.
//  Reset mid-switch aborts the switch: the next cycle shows sel_o=0, blank_o=0.
//  Synchronizer: 2-flop chain on btn_in, giving 2 cycles of latency.
//  Debounce: a counter increments while the synchronised level differs from btn_db_o and clears to 0 when they match.
//    When the count reaches DEBOUNCE_CYCLES, btn_db_o takes the new level and the counter clears.
//  Toggle request (req): one-cycle pulse on the 0->1 edge of btn_db_o. Releasing the button generates no request.
//  FSM states are SEL_A, SWITCH, SEL_B. SWITCH records its target in a 1-bit register.
//    SEL_A / SEL_B: blank_o=0. On req && !hold_i, go to SWITCH. The guard counter loads 0.
//    SWITCH: blank_o=1. The guard counter increments each cycle.
//      When the count reaches GUARD_CYCLES-1, the FSM goes to the target state next cycle.
//      In that next cycle sel_o flips and changed_o=1. blank_o returns to 0 in that same cycle.
//  Latency: a clean press flips sel_o exactly 2+DEBOUNCE_CYCLES+1+GUARD_CYCLES cycles after btn_in rises.
//  Requests arriving while in SWITCH are dropped, not queued.
//  hold_i rising during SWITCH does not cancel the switch; it completes.
//  hold_i does not stall debounce; btn_db_o keeps tracking the button.
//  Simultaneous button req and auto req in the same cycle produce exactly one switch.
//  Bounce shorter than DEBOUNCE_CYCLES never changes btn_db_o.
// CONFIGURATION
//  MUX_SEL_AUTO_EN defined: a period counter runs in SEL_A/SEL_B while auto_en_i=1 and hold_i=0.
//    When the counter reaches AUTO_PERIOD-1, it issues req and clears.
//    The counter also clears on entry to SWITCH, and whenever auto_en_i=0 or hold_i=1.
//  MUX_SEL_AUTO_EN undefined: no period counter is synthesised. auto_en_i is unused, and only the button generates req.
// STRUCTURE
//  Package mux_sel_pkg holds:
//    the state_t enum {SEL_A, SWITCH, SEL_B};
//    localparams for the counter widths, computed with $clog2 from the parameters;
//    the constant SEL_RESET = 1'b0.
//  One sub-module, mux_sel_debounce, contains the 2-flop sync, the debounce counter, btn_db_o and the rising-edge req pulse.
//  It takes parameter DEBOUNCE_CYCLES.
//  The top level holds the FSM, the guard counter and the optional auto counter.
// TESTING (DEBOUNCE_CYCLES=4, GUARD_CYCLES=2, AUTO_PERIOD=20 unless noted)
//  1. Reset: hold rst=1 for 3 cycles with btn_in=1 -> sel_o=0, blank_o=0, changed_o=0, btn_db_o=0 on every cycle.
//  2. Clean press: btn_in 0->1 at cycle 0 and held -> blank_o=1 in cycles 7-8; at cycle 9 sel_o=1 and changed_o=1 for 1 cycle.
//  3. Bounce: toggle btn_in every 2 cycles for 20 cycles, then return to 0 -> btn_db_o stays 0 and sel_o never changes.
//  4. hold_i=1 during a clean press -> no SWITCH entry and sel_o unchanged.
//     Asserting hold_i at cycle 8 of test 2 -> switch still completes at cycle 9.
//  5. Second press arriving mid-SWITCH, and reset at cycle 8 of test 2 ->
//     the press is dropped (sel flips once only); after the reset, sel_o=0 and blank_o=0.
//  6. With MUX_SEL_AUTO_EN, auto_en_i=1 and btn idle -> sel_o alternates 0,1,0.
//     Each flip is 20+2+1 cycles after the previous changed_o pulse.
//     Without the macro, the same stimulus -> sel_o stays 0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and sizing helpers for the mux select controller.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SWITCH = 2'd1,
        SEL_B  = 2'd2
    } state_t;

    localparam logic SEL_RESET = 1'b0;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int GUARD_CYCLES_DEF    = 2;
    localparam int AUTO_PERIOD_DEF     = 1000;

    // Counters run 0..max_count-1, so $clog2(max_count) bits suffice (min 1).
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DB_CNT_W    = cnt_width(DEBOUNCE_CYCLES_DEF);
    localparam int GUARD_CNT_W = cnt_width(GUARD_CYCLES_DEF);
    localparam int AUTO_CNT_W  = cnt_width(AUTO_PERIOD_DEF);

endpackage

// File: rtl/mux_sel_debounce.sv
// Button front end: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle request on each accepted press.
module mux_sel_debounce
    import mux_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db_o,
    output logic req_o
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          db_prev_r;
    logic [CW-1:0] cnt_r;

    // Synchronise the button and accept a new level only after it has stayed stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            db_prev_r <= 1'b0;
            btn_db_o  <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= btn_in;
            sync2_r   <= sync1_r;
            db_prev_r <= btn_db_o;
            if (sync2_r == btn_db_o) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                btn_db_o <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Press only: a release (1->0) never requests a toggle.
    assign req_o = btn_db_o & ~db_prev_r;

endmodule

// File: rtl/mux_select_ctrl.sv
// Mux select controller: debounced button toggles sel_o through a blanked guard window.
// Optional periodic auto-toggle is built only when MUX_SEL_AUTO_EN is defined.
module mux_select_ctrl
    import mux_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GUARD_CYCLES    = GUARD_CYCLES_DEF,
    parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic hold_i,
    input  logic auto_en_i,
    output logic sel_o,
    output logic blank_o,
    output logic changed_o,
    output logic btn_db_o
);

    localparam int             GW         = cnt_width(GUARD_CYCLES);
    localparam logic [GW-1:0]  GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0]  GUARD_ONE  = GW'(1);

    state_t        state_r;
    logic          target_r;
    logic [GW-1:0] guard_cnt_r;
    logic          btn_req_s;
    logic          auto_req_s;
    logic          req_s;
    logic          go_switch_s;

    mux_sel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .btn_db_o(btn_db_o),
        .req_o   (btn_req_s)
    );

`ifdef MUX_SEL_AUTO_EN
    localparam int             AW        = cnt_width(AUTO_PERIOD);
    localparam logic [AW-1:0]  AUTO_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [AW-1:0]  AUTO_ONE  = AW'(1);

    logic [AW-1:0] auto_cnt_r;
    logic          auto_req_r;

    // Period counter only runs while idle in a select state and enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_r <= '0;
            auto_req_r <= 1'b0;
        end else if ((state_r == SWITCH) || go_switch_s || ~auto_en_i || hold_i) begin
            auto_cnt_r <= '0;
            auto_req_r <= 1'b0;
        end else if (auto_cnt_r == AUTO_LAST) begin
            auto_cnt_r <= '0;
            auto_req_r <= 1'b1;
        end else begin
            auto_cnt_r <= auto_cnt_r + AUTO_ONE;
            auto_req_r <= 1'b0;
        end
    end

    assign auto_req_s = auto_req_r;
`else
    logic unused_auto_en_s;

    assign unused_auto_en_s = auto_en_i;
    assign auto_req_s       = 1'b0;
`endif

    // OR-ing the sources means coincident requests still give a single switch.
    assign req_s = btn_req_s | auto_req_s;

    // Switch entry is only possible from a settled select state.
    always_comb begin
        go_switch_s = 1'b0;
        case (state_r)
            SEL_A, SEL_B: go_switch_s = req_s & ~hold_i;
            default:      go_switch_s = 1'b0;
        endcase
    end

    // Select FSM: blank first, then flip sel_o on the cycle blank drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SEL_A;
            target_r    <= SEL_RESET;
            guard_cnt_r <= '0;
            sel_o       <= SEL_RESET;
            blank_o     <= 1'b0;
            changed_o   <= 1'b0;
        end else begin
            case (state_r)
                SEL_A, SEL_B: begin
                    changed_o   <= 1'b0;
                    guard_cnt_r <= '0;
                    if (go_switch_s) begin
                        state_r  <= SWITCH;
                        target_r <= (state_r == SEL_A);
                        blank_o  <= 1'b1;
                    end else begin
                        blank_o <= 1'b0;
                    end
                end
                SWITCH: begin
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_r     <= target_r ? SEL_B : SEL_A;
                        sel_o       <= target_r;
                        changed_o   <= 1'b1;
                        blank_o     <= 1'b0;
                        guard_cnt_r <= '0;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + GUARD_ONE;
                        changed_o   <= 1'b0;
                        blank_o     <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= SEL_A;
                    sel_o       <= SEL_RESET;
                    blank_o     <= 1'b0;
                    changed_o   <= 1'b0;
                    guard_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Scoreboard bench for mux_select_ctrl (DEBOUNCE=4, GUARD=2, AUTO_PERIOD=20).
// Expected {sel, blank, changed, btn_db} vectors are queued per cycle and checked after each edge.
module tb_mux_select_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic hold_i;
    logic auto_en_i;
    logic sel_o;
    logic blank_o;
    logic changed_o;
    logic btn_db_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mux_select_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .GUARD_CYCLES   (2),
        .AUTO_PERIOD    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .hold_i   (hold_i),
        .auto_en_i(auto_en_i),
        .sel_o    (sel_o),
        .blank_o  (blank_o),
        .changed_o(changed_o),
        .btn_db_o (btn_db_o)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_steady(input int from, input int n, input string tag, input logic [3:0] v);
        for (int k = 0; k < n; k++) expect_at(from + k, tag, v);
    endtask

    task automatic tick();
        exp_t e;
        int   i;
        @(posedge clk);
        #1;
        cyc++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                e = sb[i];
                sb.delete(i);
                check_value($sformatf("%s@%0d", e.tag, e.cyc),
                            {28'd0, sel_o, blank_o, changed_o, btn_db_o}, {28'd0, e.exp});
            end else begin
                i++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int t0;

    initial begin
        rst       = 1'b1;
        btn_in    = 1'b1;
        hold_i    = 1'b0;
        auto_en_i = 1'b0;

        // Reset held with button pressed: everything stays low.
        for (int k = 0; k < 3; k++) begin
            expect_at(cyc + 1, "reset", 4'b0000);
            tick();
        end
        rst    = 1'b0;
        btn_in = 1'b0;
        expect_steady(cyc + 1, 8, "idle", 4'b0000);
        ticks(8);

        // Clean press: blank at +7,+8, flip at +9.
        t0 = cyc;
        btn_in = 1'b1;
        expect_steady(t0 + 1, 5, "press_wait", 4'b0000);
        expect_at(t0 + 6, "press_db", 4'b0001);
        expect_steady(t0 + 7, 2, "press_blank", 4'b0101);
        expect_at(t0 + 9, "press_flip", 4'b1011);
        expect_steady(t0 + 10, 4, "press_after", 4'b1001);
        ticks(13);
        t0 = cyc;
        btn_in = 1'b0;
        expect_steady(t0 + 1, 5, "rel_wait", 4'b1001);
        expect_steady(t0 + 6, 6, "rel_no_req", 4'b1000);
        ticks(11);

        // Bounce with 2-cycle runs never settles.
        for (int k = 0; k < 20; k++) begin
            btn_in = (((k / 2) % 2) == 0) ? 1'b1 : 1'b0;
            expect_at(cyc + 1, "bounce", 4'b1000);
            tick();
        end
        btn_in = 1'b0;
        expect_steady(cyc + 1, 10, "bounce_end", 4'b1000);
        ticks(10);

        // Hold during a clean press: debounce tracks, no switch.
        hold_i = 1'b1;
        t0 = cyc;
        btn_in = 1'b1;
        expect_steady(t0 + 1, 5, "hold_wait", 4'b1000);
        expect_steady(t0 + 6, 6, "hold_press", 4'b1001);
        ticks(11);
        t0 = cyc;
        btn_in = 1'b0;
        expect_steady(t0 + 1, 5, "hold_rel_wait", 4'b1001);
        expect_steady(t0 + 6, 5, "hold_rel", 4'b1000);
        ticks(10);
        hold_i = 1'b0;

        // Hold raised inside the guard window: switch still completes.
        t0 = cyc;
        btn_in = 1'b1;
        expect_steady(t0 + 1, 5, "late_hold_wait", 4'b1000);
        expect_at(t0 + 6, "late_hold_db", 4'b1001);
        expect_steady(t0 + 7, 2, "late_hold_blank", 4'b1101);
        expect_at(t0 + 9, "late_hold_flip", 4'b0011);
        expect_steady(t0 + 10, 3, "late_hold_after", 4'b0001);
        ticks(7);
        hold_i = 1'b1;
        ticks(6);
        hold_i = 1'b0;
        t0 = cyc;
        btn_in = 1'b0;
        expect_steady(t0 + 1, 5, "late_rel_wait", 4'b0001);
        expect_steady(t0 + 6, 5, "late_rel", 4'b0000);
        ticks(10);

        // Second press attempt during SWITCH is dropped: exactly one flip.
        t0 = cyc;
        btn_in = 1'b1;
        expect_steady(t0 + 1, 5, "dbl_wait", 4'b0000);
        expect_at(t0 + 6, "dbl_db", 4'b0001);
        expect_steady(t0 + 7, 2, "dbl_blank", 4'b0101);
        expect_at(t0 + 9, "dbl_flip", 4'b1011);
        expect_steady(t0 + 10, 20, "dbl_once", 4'b1001);
        ticks(7);
        btn_in = 1'b0;
        ticks(2);
        btn_in = 1'b1;
        ticks(20);
        t0 = cyc;
        btn_in = 1'b0;
        expect_steady(t0 + 1, 5, "dbl_rel_wait", 4'b1001);
        expect_steady(t0 + 6, 5, "dbl_rel", 4'b1000);
        ticks(10);

        // Reset inside the guard window aborts the switch.
        t0 = cyc;
        btn_in = 1'b1;
        expect_steady(t0 + 1, 5, "rstmid_wait", 4'b1000);
        expect_at(t0 + 6, "rstmid_db", 4'b1001);
        expect_steady(t0 + 7, 2, "rstmid_blank", 4'b1101);
        expect_at(t0 + 9, "rstmid_abort", 4'b0000);
        expect_steady(t0 + 10, 8, "rstmid_after", 4'b0000);
        ticks(8);
        rst    = 1'b1;
        btn_in = 1'b0;
        tick();
        rst = 1'b0;
        ticks(8);

        // Auto-toggle: flips every 20+2+1 cycles when built in, otherwise nothing.
        t0 = cyc;
        auto_en_i = 1'b1;
`ifdef MUX_SEL_AUTO_EN
        expect_steady(t0 + 1, 20, "auto_wait", 4'b0000);
        expect_steady(t0 + 21, 2, "auto_blank1", 4'b0100);
        expect_at(t0 + 23, "auto_flip1", 4'b1010);
        expect_steady(t0 + 24, 20, "auto_wait2", 4'b1000);
        expect_steady(t0 + 44, 2, "auto_blank2", 4'b1100);
        expect_at(t0 + 46, "auto_flip2", 4'b0010);
        expect_steady(t0 + 47, 4, "auto_after", 4'b0000);
`else
        expect_steady(t0 + 1, 50, "auto_off", 4'b0000);
`endif
        ticks(50);
        auto_en_i = 1'b0;

        check_value("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
